obstacle_scheduler: RTL and testbench

OBSTACLE_SCHEDULER -- requirements
Module: obstacle_scheduler

---
 rtl/obstacle_pkg.sv | 25 ++
 rtl/obstacle_gap_timer.sv | 27 ++
 rtl/obstacle_scheduler.sv | 100 ++++++++++
 tb/tb_obstacle_scheduler.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/obstacle_pkg.sv
// rtl/obstacle_pkg.sv - shared encodings for the obstacle spawn scheduler
package obstacle_pkg;

    localparam int COUNT_W = 16;

    localparam logic [1:0] TYPE_SMALL = 2'd0;
    localparam logic [1:0] TYPE_LARGE = 2'd1;
    localparam logic [1:0] TYPE_BIRD  = 2'd2;
    localparam logic [1:0] TYPE_RSVD  = 2'd3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_ISSUE = 2'd3;

    // Small cacti are twice as likely as large cacti or birds.
    function automatic logic [1:0] type_from_rnd(input logic [1:0] sel);
        case (sel)
            2'b10:   return TYPE_LARGE;
            2'b11:   return TYPE_BIRD;
            default: return TYPE_SMALL;
        endcase
    endfunction

endpackage

// File: rtl/obstacle_gap_timer.sv
// rtl/obstacle_gap_timer.sv - 8-bit loadable down-counter with tick enable and zero flag
module obstacle_gap_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       dec,
    output logic [7:0] count,
    output logic       zero
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 8'd0;
        end else if (clr) begin
            count <= 8'd0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != 8'd0)) begin
            count <= count - 8'd1;
        end
    end

    assign zero = (count == 8'd0);

endmodule

// File: rtl/obstacle_scheduler.sv
// rtl/obstacle_scheduler.sv - paces obstacle spawn requests with a randomised tick gap
module obstacle_scheduler
    import obstacle_pkg::*;
#(
    parameter int GAP_MIN = 40,
    parameter int GAP_W   = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               tick,
    input  logic [29:0]        rnd,
    input  logic               spawn_ready,
    output logic               spawn_valid,
    output logic [1:0]         spawn_type,
    output logic [1:0]         spawn_height,
    output logic [COUNT_W-1:0] spawn_count
);

    logic [1:0]         state;
    logic [COUNT_W-1:0] count_q;
    logic               last_bird;
    logic [7:0]         gap_val;
    logic [7:0]         gap_count;
    logic               gap_zero;
    logic [1:0]         cand_type;
    logic [1:0]         cand_height;
    logic [1:0]         rnd_type;
    logic               unused_rnd;

    assign unused_rnd = ^rnd[25:GAP_W];
    assign gap_val    = 8'(GAP_MIN) + 8'(rnd[GAP_W-1:0]);
    assign rnd_type   = type_from_rnd(rnd[29:28]);

    // Two birds in a row are unjumpable at speed, so a second bird becomes a small cactus.
    always_comb begin
        cand_type   = rnd_type;
        cand_height = 2'd0;
        if (rnd_type == TYPE_BIRD) begin
            if (last_bird) begin
                cand_type = TYPE_SMALL;
            end else if (rnd[27:26] != 2'd3) begin
                cand_height = rnd[27:26];
            end
        end
    end

    obstacle_gap_timer u_gap_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (!enable),
        .load     (state == ST_LOAD),
        .load_val (gap_val),
        .dec      ((state == ST_WAIT) && tick),
        .count    (gap_count),
        .zero     (gap_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            spawn_valid  <= 1'b0;
            spawn_type   <= TYPE_SMALL;
            spawn_height <= 2'd0;
            count_q      <= '0;
            last_bird    <= 1'b0;
        end else if (!enable) begin
            state       <= ST_IDLE;
            spawn_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state <= ST_LOAD;
                end
                ST_LOAD: begin
                    spawn_type   <= cand_type;
                    spawn_height <= cand_height;
                    state        <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (gap_zero || (tick && (gap_count == 8'd1))) begin
                        spawn_valid <= 1'b1;
                        state       <= ST_ISSUE;
                    end
                end
                default: begin
                    if (spawn_valid && spawn_ready) begin
                        spawn_valid <= 1'b0;
                        count_q     <= count_q + 1'b1;
                        last_bird   <= (spawn_type == TYPE_BIRD);
                        state       <= ST_LOAD;
                    end
                end
            endcase
        end
    end

    assign spawn_count = count_q;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// tb/tb_obstacle_scheduler.sv - directed self-checking bench for obstacle_scheduler
module tb_obstacle_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        tick;
    logic [29:0] rnd;
    logic        ready;
    logic        spawn_valid;
    logic [1:0]  spawn_type;
    logic [1:0]  spawn_height;
    logic [15:0] spawn_count;

    logic        w_enable;
    logic        w_tick;
    logic [29:0] w_rnd;
    logic        w_ready;
    logic        w_valid;
    logic [1:0]  w_type;
    logic [1:0]  w_height;
    logic [15:0] w_count;

    int vectors    = 0;
    int miscompares = 0;
    bit ok;

    always #5 clk = ~clk;

    obstacle_scheduler u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .tick         (tick),
        .rnd          (rnd),
        .spawn_ready  (ready),
        .spawn_valid  (spawn_valid),
        .spawn_type   (spawn_type),
        .spawn_height (spawn_height),
        .spawn_count  (spawn_count)
    );

    obstacle_scheduler #(.GAP_MIN(1), .GAP_W(5)) u_wrap (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (w_enable),
        .tick         (w_tick),
        .rnd          (w_rnd),
        .spawn_ready  (w_ready),
        .spawn_valid  (w_valid),
        .spawn_type   (w_type),
        .spawn_height (w_height),
        .spawn_count  (w_count)
    );

    task automatic do_reset();
        rst_n  = 1'b0;
        enable = 1'b0;
        tick   = 1'b0;
        ready  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (spawn_valid) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_w_valid(input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (w_valid) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        enable = 1'b1;
        tick   = 1'b1;
        ready  = 1'b1;
        rnd    = 30'h3FFFFFFF;
        repeat (3) @(negedge clk);
        vectors++;
        if ({spawn_valid, spawn_type, spawn_height, spawn_count} !== 21'd0) begin
            miscompares++;
            $display("FAIL reset_state: got %h expected %h",
                     {spawn_valid, spawn_type, spawn_height, spawn_count}, 21'd0);
        end
        enable = 1'b0;
        rst_n  = 1'b1;
    endtask

    task automatic test_latency();
        do_reset();
        rnd   = 30'h20000029;
        ready = 1'b1;
        @(negedge clk);
        enable = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 1; k <= 49; k++) begin
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
            if (k == 48) begin
                vectors++;
                if (spawn_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL latency_early: valid %b after 48 ticks, expected 0", spawn_valid);
                end
            end
            if (k < 49) repeat (3) @(negedge clk);
        end
        vectors++;
        if ({spawn_valid, spawn_type, spawn_height, spawn_count} !== {1'b1, 2'd1, 2'd0, 16'd0}) begin
            miscompares++;
            $display("FAIL latency_issue: got %h expected %h",
                     {spawn_valid, spawn_type, spawn_height, spawn_count}, {1'b1, 2'd1, 2'd0, 16'd0});
        end
        @(negedge clk);
        vectors++;
        if ({spawn_valid, spawn_count} !== {1'b0, 16'd1}) begin
            miscompares++;
            $display("FAIL latency_accept: got %h expected %h", {spawn_valid, spawn_count}, {1'b0, 16'd1});
        end
    endtask

    task automatic test_bird_suppression();
        logic [3:0] sel   [5];
        logic [1:0] exp_t [5];
        logic [1:0] exp_h [5];
        sel   = '{4'b1110, 4'b1110, 4'b1110, 4'b0100, 4'b1111};
        exp_t = '{2'd2, 2'd0, 2'd2, 2'd0, 2'd2};
        exp_h = '{2'd2, 2'd0, 2'd2, 2'd0, 2'd0};
        do_reset();
        rnd    = {sel[0], 26'd0};
        tick   = 1'b1;
        ready  = 1'b1;
        enable = 1'b1;
        for (int n = 0; n < 5; n++) begin
            wait_valid(200, ok);
            vectors++;
            if (!ok) begin
                miscompares++;
                $display("FAIL bird_timeout: spawn %0d valid never seen, expected 1", n);
            end
            vectors++;
            if ({spawn_type, spawn_height} !== {exp_t[n], exp_h[n]}) begin
                miscompares++;
                $display("FAIL bird_spawn%0d: got type %0d height %0d expected type %0d height %0d",
                         n, spawn_type, spawn_height, exp_t[n], exp_h[n]);
            end
            if (n < 4) rnd = {sel[n+1], 26'd0};
        end
        @(negedge clk);
        vectors++;
        if (spawn_count !== 16'd5) begin
            miscompares++;
            $display("FAIL bird_count: got %0d expected 5", spawn_count);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        rnd    = 30'h20000000;
        tick   = 1'b1;
        enable = 1'b1;
        wait_valid(200, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL bp_timeout: valid never seen, expected 1");
        end
        rnd = 30'h3FFFFFFF;
        for (int i = 0; i < 10; i++) begin
            tick = i[0];
            @(negedge clk);
            vectors++;
            if ({spawn_valid, spawn_type, spawn_height, spawn_count} !== {1'b1, 2'd1, 2'd0, 16'd0}) begin
                miscompares++;
                $display("FAIL bp_hold%0d: got %h expected %h", i,
                         {spawn_valid, spawn_type, spawn_height, spawn_count}, {1'b1, 2'd1, 2'd0, 16'd0});
            end
        end
        ready = 1'b1;
        @(negedge clk);
        vectors++;
        if ({spawn_valid, spawn_count} !== {1'b0, 16'd1}) begin
            miscompares++;
            $display("FAIL bp_release: got %h expected %h", {spawn_valid, spawn_count}, {1'b0, 16'd1});
        end
    endtask

    task automatic test_enable_drop();
        do_reset();
        rnd    = 30'h00000000;
        tick   = 1'b1;
        enable = 1'b1;
        wait_valid(200, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL drop_timeout: valid never seen, expected 1");
        end
        enable = 1'b0;
        @(negedge clk);
        vectors++;
        if ({spawn_valid, spawn_count} !== {1'b0, 16'd0}) begin
            miscompares++;
            $display("FAIL drop_withdraw: got %h expected %h", {spawn_valid, spawn_count}, {1'b0, 16'd0});
        end
        ready = 1'b1;
        tick  = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({spawn_valid, spawn_count} !== {1'b0, 16'd0}) begin
            miscompares++;
            $display("FAIL drop_idle_ready: got %h expected %h", {spawn_valid, spawn_count}, {1'b0, 16'd0});
        end
        rnd    = 30'h00000005;
        enable = 1'b1;
        repeat (2) @(negedge clk);
        tick = 1'b1;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            if (k == 44) begin
                vectors++;
                if (spawn_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL drop_regap_early: valid %b after 44 ticks, expected 0", spawn_valid);
                end
            end
        end
        tick = 1'b0;
        vectors++;
        if (spawn_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL drop_regap: valid %b after 45 ticks, expected 1", spawn_valid);
        end
        @(negedge clk);
        vectors++;
        if ({spawn_valid, spawn_count} !== {1'b0, 16'd1}) begin
            miscompares++;
            $display("FAIL drop_accept: got %h expected %h", {spawn_valid, spawn_count}, {1'b0, 16'd1});
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        rnd    = 30'h20000003;
        tick   = 1'b1;
        ready  = 1'b1;
        enable = 1'b1;
        wait_valid(200, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL areset_timeout: valid never seen, expected 1");
        end
        repeat (6) @(negedge clk);
        vectors++;
        if ({spawn_valid, spawn_type, spawn_count} !== {1'b0, 2'd1, 16'd1}) begin
            miscompares++;
            $display("FAIL areset_pre: got %h expected %h",
                     {spawn_valid, spawn_type, spawn_count}, {1'b0, 2'd1, 16'd1});
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({spawn_valid, spawn_type, spawn_height, spawn_count} !== 21'd0) begin
            miscompares++;
            $display("FAIL areset_mid_wait: got %h expected %h",
                     {spawn_valid, spawn_type, spawn_height, spawn_count}, 21'd0);
        end
        tick = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        tick = 1'b1;
        for (int k = 1; k <= 43; k++) begin
            @(negedge clk);
            if (k == 42) begin
                vectors++;
                if (spawn_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL release_early: valid %b after 42 ticks, expected 0", spawn_valid);
                end
            end
        end
        vectors++;
        if ({spawn_valid, spawn_type} !== {1'b1, 2'd1}) begin
            miscompares++;
            $display("FAIL release_load: got %h expected %h", {spawn_valid, spawn_type}, {1'b1, 2'd1});
        end
        tick = 1'b0;
    endtask

    task automatic test_count_wrap();
        do_reset();
        enable   = 1'b0;
        w_rnd    = 30'h00000000;
        w_tick   = 1'b1;
        w_ready  = 1'b1;
        w_enable = 1'b1;
        for (int n = 0; n < 5; n++) begin
            wait_w_valid(20, ok);
            vectors++;
            if (!ok) begin
                miscompares++;
                $display("FAIL wrap_fast_timeout: spawn %0d valid never seen, expected 1", n);
            end
        end
        @(negedge clk);
        vectors++;
        if (w_count !== 16'd5) begin
            miscompares++;
            $display("FAIL wrap_fast_count: got %0d expected 5", w_count);
        end
        w_ready = 1'b0;
        wait_w_valid(20, ok);
        force u_wrap.count_q = 16'hFFFE;
        @(negedge clk);
        release u_wrap.count_q;
        w_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if ({w_valid, w_count} !== {1'b0, 16'hFFFF}) begin
            miscompares++;
            $display("FAIL wrap_ffff: got %h expected %h", {w_valid, w_count}, {1'b0, 16'hFFFF});
        end
        wait_w_valid(20, ok);
        @(negedge clk);
        vectors++;
        if ({w_valid, w_count} !== {1'b0, 16'h0000}) begin
            miscompares++;
            $display("FAIL wrap_zero: got %h expected %h", {w_valid, w_count}, {1'b0, 16'h0000});
        end
        w_enable = 1'b0;
    endtask

    initial begin
        w_enable = 1'b0;
        w_tick   = 1'b0;
        w_rnd    = 30'd0;
        w_ready  = 1'b0;
        test_reset();
        test_latency();
        test_bird_suppression();
        test_backpressure();
        test_enable_drop();
        test_async_reset();
        test_count_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
